// File: rtl/eu_dispatch_buffer_pkg.sv
`default_nettype none
//==============================================================================
// Module      : eu_dispatch_buffer_pkg
// Description : Shared datatypes for the iqueue -> EU dispatch path.
//               type_iqueue_entry is the dispatched instruction record.
//               type_dispatch_lane_t bundles one dispatch lane (entry, valid,
//               target EU index).
// Revision    : 1.0  initial release
//==============================================================================

`ifndef NUM_PARALLEL_INSTR_DISPATCHES
`define NUM_PARALLEL_INSTR_DISPATCHES 2
`endif

`ifndef LOG2_NUM_EXEC_UNITS
`define LOG2_NUM_EXEC_UNITS 2
`endif

package eu_dispatch_buffer_pkg;

   localparam int c_iq_payload_w = 32;
   localparam int c_iq_tag_w     = 8;
   localparam int c_euidx_w      = `LOG2_NUM_EXEC_UNITS;

   typedef struct packed {
      logic [c_iq_tag_w-1:0]     tag;
      logic [c_iq_payload_w-1:0] payload;
   } type_iqueue_entry;

   typedef struct packed {
      type_iqueue_entry       entry;
      logic                   valid;
      logic [c_euidx_w-1:0]   alloc_euidx;
   } type_dispatch_lane_t;

endpackage

`default_nettype wire

// File: rtl/eu_dispatch_buffer_if.sv
`default_nettype none
//==============================================================================
// Module      : eu_dispatch_buffer_if
// Description : Dispatch + issue bundle of one EU dispatch buffer.
//               master : iqueue / EU side (drives dispatch lanes, issue
//                        ready and flush)
//               slave  : the dispatch buffer
// Signals     : dispatched_instr_i, dispatched_instr_valid_i,
//               dispatched_instr_alloc_euidx_i, ready_for_next_instrs_o,
//               issue_entry_o, issue_valid_o, issue_ready_i, flush_i,
//               occupancy_o, overflow_err_o
// Revision    : 1.0  initial release
//==============================================================================
interface eu_dispatch_buffer_if #(
   parameter int NUM_DISPATCH        = `NUM_PARALLEL_INSTR_DISPATCHES,
   parameter int LOG2_NUM_EXEC_UNITS = `LOG2_NUM_EXEC_UNITS,
   parameter int LOG2_DEPTH          = 3
);
   import eu_dispatch_buffer_pkg::*;

   type_iqueue_entry                 dispatched_instr_i             [NUM_DISPATCH];
   logic [NUM_DISPATCH-1:0]          dispatched_instr_valid_i;
   logic [LOG2_NUM_EXEC_UNITS-1:0]   dispatched_instr_alloc_euidx_i [NUM_DISPATCH];
   logic                             ready_for_next_instrs_o;
   type_iqueue_entry                 issue_entry_o;
   logic                             issue_valid_o;
   logic                             issue_ready_i;
   logic                             flush_i;
   logic [LOG2_DEPTH:0]              occupancy_o;
   logic                             overflow_err_o;

   modport master (
      output dispatched_instr_i, dispatched_instr_valid_i,
             dispatched_instr_alloc_euidx_i, issue_ready_i, flush_i,
      input  ready_for_next_instrs_o, issue_entry_o, issue_valid_o,
             occupancy_o, overflow_err_o
   );

   modport slave (
      input  dispatched_instr_i, dispatched_instr_valid_i,
             dispatched_instr_alloc_euidx_i, issue_ready_i, flush_i,
      output ready_for_next_instrs_o, issue_entry_o, issue_valid_o,
             occupancy_o, overflow_err_o
   );

endinterface

`default_nettype wire

// File: rtl/eu_dispatch_buffer_lane_compactor.sv
`default_nettype none
//==============================================================================
// Module      : eu_lane_compactor
// Description : Combinational prefix popcount over the lane hit mask. Each
//               hitting lane gets the number of hitting lanes below it as its
//               write offset, so hits pack densely in ascending lane order.
// Ports       : i_hit     - per-lane hit mask
//               o_offset  - per-lane write offset (meaningful for hit lanes)
//               o_count   - total number of hits H
// Revision    : 1.0  initial release
//==============================================================================
module eu_lane_compactor #(
   parameter int NUM_DISPATCH = 2,
   parameter int CNT_W        = $clog2(NUM_DISPATCH + 1)
) (
   input  wire logic [NUM_DISPATCH-1:0] i_hit,
   output logic      [CNT_W-1:0]        o_offset [NUM_DISPATCH],
   output logic      [CNT_W-1:0]        o_count
);

   logic [CNT_W-1:0] w_run;

   always_comb begin
      w_run = '0;
      for (int k = 0; k < NUM_DISPATCH; k++) begin
         o_offset[k] = w_run;
         w_run       = w_run + CNT_W'(i_hit[k]);
      end
      o_count = w_run;
   end

endmodule

`default_nettype wire

// File: rtl/eu_dispatch_buffer.sv
`default_nettype none
//==============================================================================
// Module      : eu_dispatch_buffer
// Description : Per-EU instruction buffer. Snoops all dispatch lanes, packs
//               the lanes targeting EU_IDX into a circular buffer in lane
//               order, and presents the oldest entry over valid/ready.
// Ports       : clk      - clock
//               reset_n  - synchronous active-low reset
//               bus      - dispatch lanes, issue handshake, flush,
//                          back-pressure, occupancy and sticky overflow
// Revision    : 1.0  initial release
//==============================================================================
module eu_dispatch_buffer
   import eu_dispatch_buffer_pkg::*;
#(
   parameter int NUM_DISPATCH        = `NUM_PARALLEL_INSTR_DISPATCHES,
   parameter int LOG2_NUM_EXEC_UNITS = `LOG2_NUM_EXEC_UNITS,
   parameter int EU_IDX              = 0,
   parameter int LOG2_DEPTH          = 3
) (
   input wire logic              clk,
   input wire logic              reset_n,
   eu_dispatch_buffer_if.slave   bus
);

   localparam int c_depth = 2 ** LOG2_DEPTH;
   localparam int c_cnt_w = LOG2_DEPTH + 1;
   localparam int c_hit_w = $clog2(NUM_DISPATCH + 1);
   localparam logic [LOG2_NUM_EXEC_UNITS-1:0] c_eu_idx = LOG2_NUM_EXEC_UNITS'(EU_IDX);

   generate
      if (c_depth < 2 * NUM_DISPATCH) begin : g_depth_check
         $error("eu_dispatch_buffer: DEPTH must be at least 2*NUM_DISPATCH");
      end
   endgenerate

   type_iqueue_entry              r_storage [c_depth];
   logic [LOG2_DEPTH-1:0]         r_head;
   logic [LOG2_DEPTH-1:0]         r_tail;
   logic [c_cnt_w-1:0]            r_count;
   logic                          r_ready;
   logic                          r_overflow;

   type_dispatch_lane_t           w_lane     [NUM_DISPATCH];
   logic [NUM_DISPATCH-1:0]       w_hit;
   logic [c_hit_w-1:0]            w_offset   [NUM_DISPATCH];
   logic [c_hit_w-1:0]            w_hit_count;
   logic [LOG2_DEPTH-1:0]         w_wr_idx   [NUM_DISPATCH];
   logic                          w_push_ok;
   logic [c_hit_w-1:0]            w_h_acc;
   logic                          w_pop;
   logic [c_cnt_w-1:0]            w_count_next;
   logic                          w_ready_next;

   generate
      for (genvar k = 0; k < NUM_DISPATCH; k++) begin : g_lane
         assign w_lane[k].entry       = bus.dispatched_instr_i[k];
         assign w_lane[k].valid       = bus.dispatched_instr_valid_i[k];
         assign w_lane[k].alloc_euidx = bus.dispatched_instr_alloc_euidx_i[k];
         assign w_hit[k]    = w_lane[k].valid && (w_lane[k].alloc_euidx == c_eu_idx);
         assign w_wr_idx[k] = r_tail + LOG2_DEPTH'(w_offset[k]);
      end
   endgenerate

   eu_lane_compactor #(
      .NUM_DISPATCH (NUM_DISPATCH),
      .CNT_W        (c_hit_w)
   ) u_compactor (
      .i_hit    (w_hit),
      .o_offset (w_offset),
      .o_count  (w_hit_count)
   );

   // A flush cycle swallows both the push and the pop.
   assign w_push_ok    = r_ready && !bus.flush_i;
   assign w_h_acc      = w_push_ok ? w_hit_count : '0;
   assign w_pop        = (r_count != '0) && bus.issue_ready_i && !bus.flush_i;
   assign w_count_next = r_count + c_cnt_w'(w_h_acc) - c_cnt_w'(w_pop);
   // Ready promises room for a whole dispatch group next cycle.
   assign w_ready_next = (c_cnt_w'(c_depth) - w_count_next) >= c_cnt_w'(NUM_DISPATCH);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_ready    <= 1'b1;
         r_overflow <= 1'b0;
      end else if (bus.flush_i) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_ready <= 1'b0;
      end else begin
         if (w_pop) begin
            r_head <= r_head + 1'b1;
         end
         r_tail  <= r_tail + LOG2_DEPTH'(w_h_acc);
         r_count <= w_count_next;
         r_ready <= w_ready_next;
         if ((w_hit_count != '0) && !r_ready) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Storage is data-only; validity lives in r_count, so no reset here.
   always_ff @(posedge clk) begin
      if (reset_n && w_push_ok) begin
         for (int k = 0; k < NUM_DISPATCH; k++) begin
            if (w_hit[k]) begin
               r_storage[w_wr_idx[k]] <= w_lane[k].entry;
            end
         end
      end
   end

   assign bus.ready_for_next_instrs_o = r_ready;
   assign bus.issue_valid_o           = (r_count != '0);
   assign bus.issue_entry_o           = r_storage[r_head];
   assign bus.occupancy_o             = r_count;
   assign bus.overflow_err_o          = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_eu_dispatch_buffer.sv
`default_nettype none
//==============================================================================
// Module      : tb_eu_dispatch_buffer
// Description : Self-checking bench for eu_dispatch_buffer (2 lanes, EU 1,
//               depth 8): directed vector table, hand sequences for reset,
//               latency, flush and wrap-around, then random traffic against a
//               queue-based reference model.
// Revision    : 1.0  initial release
//==============================================================================
module tb_eu_dispatch_buffer;
   import eu_dispatch_buffer_pkg::*;

   localparam int c_nd    = 2;
   localparam int c_ldep  = 3;
   localparam int c_depth = 8;

   logic clk = 1'b0;
   logic reset_n;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   eu_dispatch_buffer_if #(.NUM_DISPATCH(c_nd), .LOG2_NUM_EXEC_UNITS(2), .LOG2_DEPTH(c_ldep)) bus ();

   eu_dispatch_buffer #(
      .NUM_DISPATCH(c_nd), .LOG2_NUM_EXEC_UNITS(2), .EU_IDX(1), .LOG2_DEPTH(c_ldep)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      logic [1:0] v;
      logic [1:0] eu0;
      logic [1:0] eu1;
      logic [7:0] e0;
      logic [7:0] e1;
      logic       ir;
      logic [3:0] occ;
      logic       vld;
      logic       rdy;
      logic       ovf;
      logic [7:0] ent;
   } vec_t;

   vec_t tbl [16];

   // Reference model state
   type_iqueue_entry m_q[$];
   logic             m_rdy;
   logic             m_ovf;

   function automatic type_iqueue_entry mk(input logic [7:0] e);
      type_iqueue_entry r;
      r.tag     = e;
      r.payload = {4{e}};
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.dispatched_instr_valid_i = '0;
      for (int k = 0; k < c_nd; k++) begin
         bus.dispatched_instr_i[k]             = mk(8'h00);
         bus.dispatched_instr_alloc_euidx_i[k] = 2'd0;
      end
      bus.issue_ready_i = 1'b0;
      bus.flush_i       = 1'b0;
   endtask

   task automatic drive(input logic [1:0] v, input logic [1:0] eu0, input logic [1:0] eu1,
                        input logic [7:0] e0, input logic [7:0] e1, input logic ir);
      bus.dispatched_instr_valid_i          = v;
      bus.dispatched_instr_alloc_euidx_i[0] = eu0;
      bus.dispatched_instr_alloc_euidx_i[1] = eu1;
      bus.dispatched_instr_i[0]             = mk(e0);
      bus.dispatched_instr_i[1]             = mk(e1);
      bus.issue_ready_i                     = ir;
   endtask

   // Effect of one clock edge, stated directly from the buffer's rules.
   task automatic model_step();
      int nh;
      if (!reset_n) begin
         m_q.delete();
         m_rdy = 1'b1;
         m_ovf = 1'b0;
      end else if (bus.flush_i) begin
         m_q.delete();
         m_rdy = 1'b0;
      end else begin
         nh = 0;
         for (int k = 0; k < c_nd; k++)
            if (bus.dispatched_instr_valid_i[k] && bus.dispatched_instr_alloc_euidx_i[k] == 2'd1) nh++;
         if (m_q.size() > 0 && bus.issue_ready_i) void'(m_q.pop_front());
         if (nh > 0) begin
            if (m_rdy) begin
               for (int k = 0; k < c_nd; k++)
                  if (bus.dispatched_instr_valid_i[k] && bus.dispatched_instr_alloc_euidx_i[k] == 2'd1)
                     m_q.push_back(bus.dispatched_instr_i[k]);
            end else begin
               m_ovf = 1'b1;
            end
         end
         m_rdy = (c_depth - m_q.size()) >= c_nd;
      end
   endtask

   initial begin
      type_iqueue_entry got[$];
      int max_occ;

      //             v      eu0  eu1  e0     e1     ir    occ  vld   rdy   ovf   ent
      tbl[0]  = '{2'b11, 2'd1, 2'd0, 8'h0A, 8'h0F, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0, 8'h0A};
      tbl[1]  = '{2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 8'h00};
      tbl[2]  = '{2'b11, 2'd2, 2'd1, 8'h0E, 8'h0B, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0, 8'h0B};
      tbl[3]  = '{2'b11, 2'd1, 2'd1, 8'h0C, 8'h0D, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 8'h0B};
      tbl[4]  = '{2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0, 8'h0C};
      tbl[5]  = '{2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1, 4'd1, 1'b1, 1'b1, 1'b0, 8'h0D};
      tbl[6]  = '{2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 8'h00};
      tbl[7]  = '{2'b11, 2'd1, 2'd1, 8'h10, 8'h11, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0, 8'h10};
      tbl[8]  = '{2'b11, 2'd1, 2'd1, 8'h12, 8'h13, 1'b0, 4'd4, 1'b1, 1'b1, 1'b0, 8'h10};
      tbl[9]  = '{2'b11, 2'd1, 2'd1, 8'h14, 8'h15, 1'b0, 4'd6, 1'b1, 1'b1, 1'b0, 8'h10};
      tbl[10] = '{2'b11, 2'd1, 2'd0, 8'h16, 8'hEE, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0, 8'h10};
      tbl[11] = '{2'b01, 2'd1, 2'd0, 8'h17, 8'h00, 1'b0, 4'd7, 1'b1, 1'b0, 1'b1, 8'h10};
      tbl[12] = '{2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1, 4'd6, 1'b1, 1'b1, 1'b1, 8'h11};
      tbl[13] = '{2'b11, 2'd1, 2'd1, 8'h18, 8'h19, 1'b1, 4'd7, 1'b1, 1'b0, 1'b1, 8'h12};
      tbl[14] = '{2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1, 4'd6, 1'b1, 1'b1, 1'b1, 8'h13};
      tbl[15] = '{2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1, 4'd5, 1'b1, 1'b1, 1'b1, 8'h14};

      idle();
      reset_n = 1'b0;
      tick();
      tick();
      chk("reset_occ", 64'(bus.occupancy_o), 64'd0);
      chk("reset_valid", 64'(bus.issue_valid_o), 64'd0);
      chk("reset_ready", 64'(bus.ready_for_next_instrs_o), 64'd1);
      chk("reset_ovf", 64'(bus.overflow_err_o), 64'd0);
      reset_n = 1'b1;

      // Directed vector table
      for (int i = 0; i < 16; i++) begin
         drive(tbl[i].v, tbl[i].eu0, tbl[i].eu1, tbl[i].e0, tbl[i].e1, tbl[i].ir);
         tick();
         chk($sformatf("tbl%0d_occ", i), 64'(bus.occupancy_o), 64'(tbl[i].occ));
         chk($sformatf("tbl%0d_valid", i), 64'(bus.issue_valid_o), 64'(tbl[i].vld));
         chk($sformatf("tbl%0d_ready", i), 64'(bus.ready_for_next_instrs_o), 64'(tbl[i].rdy));
         chk($sformatf("tbl%0d_ovf", i), 64'(bus.overflow_err_o), 64'(tbl[i].ovf));
         if (tbl[i].vld)
            chk($sformatf("tbl%0d_entry", i), 64'(bus.issue_entry_o), 64'(mk(tbl[i].ent)));
      end

      // Reset in the middle of traffic (occupancy 5, overflow set)
      idle();
      reset_n = 1'b0;
      tick();
      chk("midrst_occ", 64'(bus.occupancy_o), 64'd0);
      chk("midrst_valid", 64'(bus.issue_valid_o), 64'd0);
      chk("midrst_ready", 64'(bus.ready_for_next_instrs_o), 64'd1);
      chk("midrst_ovf", 64'(bus.overflow_err_o), 64'd0);
      reset_n = 1'b1;

      // No bypass: empty buffer with ready high still shows the entry next cycle
      drive(2'b01, 2'd1, 2'd0, 8'h40, 8'h00, 1'b1);
      tick();
      chk("lat_occ", 64'(bus.occupancy_o), 64'd1);
      chk("lat_entry", 64'(bus.issue_entry_o), 64'(mk(8'h40)));
      idle();
      bus.issue_ready_i = 1'b1;
      tick();
      chk("lat_drain", 64'(bus.occupancy_o), 64'd0);

      // Flush at occupancy 5 with a concurrent 2-hit push
      drive(2'b11, 2'd1, 2'd1, 8'h50, 8'h51, 1'b0); tick();
      drive(2'b11, 2'd1, 2'd1, 8'h52, 8'h53, 1'b0); tick();
      drive(2'b01, 2'd1, 2'd1, 8'h54, 8'h00, 1'b0); tick();
      chk("preflush_occ", 64'(bus.occupancy_o), 64'd5);
      drive(2'b11, 2'd1, 2'd1, 8'h60, 8'h61, 1'b1);
      bus.flush_i = 1'b1;
      tick();
      chk("flush_occ", 64'(bus.occupancy_o), 64'd0);
      chk("flush_valid", 64'(bus.issue_valid_o), 64'd0);
      chk("flush_ready", 64'(bus.ready_for_next_instrs_o), 64'd0);
      chk("flush_ovf", 64'(bus.overflow_err_o), 64'd0);
      idle();
      tick();
      chk("postflush_ready", 64'(bus.ready_for_next_instrs_o), 64'd1);
      chk("postflush_occ", 64'(bus.occupancy_o), 64'd0);

      // Wrap-around: 20 entries streamed one per cycle
      max_occ = 0;
      for (int i = 0; i < 24; i++) begin
         if (i < 20) drive(2'b01, 2'd1, 2'd0, 8'(i), 8'h00, 1'b1);
         else        drive(2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1);
         if (bus.issue_valid_o) got.push_back(bus.issue_entry_o);
         tick();
         if (int'(bus.occupancy_o) > max_occ) max_occ = int'(bus.occupancy_o);
      end
      chk("wrap_count", 64'(got.size()), 64'd20);
      for (int i = 0; i < got.size() && i < 20; i++)
         chk($sformatf("wrap_seq%0d", i), 64'(got[i]), 64'(mk(8'(i))));
      chk("wrap_maxocc_ok", 64'(max_occ <= c_depth), 64'd1);

      // Random traffic against the reference model
      idle();
      reset_n = 1'b0;
      model_step();
      tick();
      reset_n = 1'b1;
      for (int c = 0; c < 800; c++) begin
         for (int k = 0; k < c_nd; k++) begin
            bus.dispatched_instr_valid_i[k]       = 1'($urandom_range(0, 1));
            bus.dispatched_instr_alloc_euidx_i[k] = ($urandom_range(0, 1) == 1) ? 2'd1 : 2'($urandom_range(0, 3));
            bus.dispatched_instr_i[k]             = mk(8'($urandom));
            bus.dispatched_instr_i[k].payload     = $urandom;
         end
         // Alternate phases of strong and weak consumption to reach full
         bus.issue_ready_i = ((c / 50) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         bus.flush_i       = ($urandom_range(0, 39) == 0);
         reset_n           = ($urandom_range(0, 199) != 0);
         model_step();
         tick();
         chk("rnd_occ", 64'(bus.occupancy_o), 64'(m_q.size()));
         chk("rnd_valid", 64'(bus.issue_valid_o), 64'(m_q.size() != 0));
         chk("rnd_ready", 64'(bus.ready_for_next_instrs_o), 64'(m_rdy));
         chk("rnd_ovf", 64'(bus.overflow_err_o), 64'(m_ovf));
         if (m_q.size() != 0)
            chk("rnd_entry", 64'(bus.issue_entry_o), 64'(m_q[0]));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/eu_dispatch_buffer.md
Name: eu_dispatch_buffer

Overview:
Per-execution-unit instruction buffer between the iqueue dispatch lanes and the EU's issue logic. Each cycle it snoops all parallel dispatch lanes, captures the entries allocated to its own EU index, and writes them in lane order into a circular buffer. It presents the oldest entry to the EU over a valid/ready issue handshake, and drives a registered back-pressure signal to the iqueue. Dispatch width, buffer depth and EU index are generalised as parameters.

Parameters:
- NUM_DISPATCH, default `NUM_PARALLEL_INSTR_DISPATCHES (2): number of parallel dispatch lanes.
- LOG2_NUM_EXEC_UNITS, default `LOG2_NUM_EXEC_UNITS (2): width of the EU index.
- EU_IDX, default 0: index of this EU; a lane hits when its alloc index equals EU_IDX.
- LOG2_DEPTH, default 3: DEPTH = 2**LOG2_DEPTH entries. Requires DEPTH >= 2*NUM_DISPATCH.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- dispatched_instr_i  in  NUM_DISPATCH x type_iqueue_entry  dispatched entries, one per lane
- dispatched_instr_valid_i  in  NUM_DISPATCH x 1  per-lane valid
- dispatched_instr_alloc_euidx_i  in  NUM_DISPATCH x LOG2_NUM_EXEC_UNITS  per-lane target EU
- ready_for_next_instrs_o  out  1  registered; buffer can absorb a full dispatch group
- issue_entry_o  out  type_iqueue_entry  oldest buffered entry
- issue_valid_o  out  1  buffer not empty
- issue_ready_i  in  1  EU consumes head this cycle
- flush_i  in  1  discard all buffered entries
- occupancy_o  out  LOG2_DEPTH+1  current entry count
- overflow_err_o  out  1  sticky; a hit arrived while ready was low

Behaviour:
- Reset, when reset_n is low at a clk edge:
  - head, tail and count are set to 0.
  - ready_for_next_instrs_o = 1, issue_valid_o = 0, occupancy_o = 0, overflow_err_o = 0.
  - Storage contents are not reset.
- Hit definition: lane k hits when dispatched_instr_valid_i[k] is high and dispatched_instr_alloc_euidx_i[k] == EU_IDX. The number of hits H ranges from 0 to NUM_DISPATCH.
- Push:
  - Pushing is allowed only when ready_for_next_instrs_o is high and flush_i is low.
  - Hits are written in ascending lane order to tail, tail+1, and so on, modulo DEPTH. Lanes that do not hit leave no gaps.
  - tail advances by H and wraps naturally on LOG2_DEPTH bits.
- Pop: when issue_valid_o and issue_ready_i are both high, head advances by 1 at the edge.
- count_next = count + H_accepted − pop. Push and pop in the same cycle are both honoured.
- Latency: a pushed entry appears on issue_entry_o one cycle later, with no bypass. This holds even when the buffer is empty and issue_ready_i is high.
- issue_valid_o = (count != 0). It is combinational from count.
- issue_entry_o = storage[head]. Its value is don't-care while issue_valid_o is low.
- ready_for_next_instrs_o:
  - It is registered, so the iqueue sees a stable value for the whole cycle.
  - Next value = (DEPTH − count_next >= NUM_DISPATCH) and not flush_i.
  - It therefore drops in the cycle after a push that leaves fewer than NUM_DISPATCH free slots.
- Overflow: hits with H > 0 while ready_for_next_instrs_o is low are dropped, and overflow_err_o is set. overflow_err_o clears only on reset.
- Flush:
  - flush_i high at an edge sets head = tail = count = 0.
  - Any same-cycle push or pop is ignored.
  - ready_for_next_instrs_o is 0 in the following cycle, then re-evaluates (becoming 1).
  - Hits in the flush cycle are discarded without setting overflow_err_o.
- Full/empty: count is the sole full/empty indicator, so head == tail is ambiguous without it. Count saturates at neither end; the ready rule guarantees count <= DEPTH.
- Reset mid-operation: reset takes priority over flush, push and pop; state returns to the reset values.

Decomposition:
- pkg_dtypes already holds type_iqueue_entry. Add to it a typedef for a per-lane dispatch bundle (entry, valid, alloc_euidx), so this block and intf_eu share one definition.
- Sub-module eu_lane_compactor (combinational): maps the hit mask to per-lane write offsets (a prefix popcount) plus H.
- The top level holds pointers, count, storage and flags.

Test Plan:
- Single lane: NUM_DISPATCH=2, EU_IDX=1; lane0 valid with euidx=1, entry=0xA; lane1 euidx=0 -> occupancy 1 next cycle, issue_entry_o=0xA, lane1 ignored.
- Lane compaction: lane0 euidx=2 (miss), lane1 euidx=1, entry=0xB -> 0xB written at slot 0; next push (0xC, 0xD on both lanes) issues in order B, C, D.
- Back-pressure: DEPTH=8, fill to 7 with issue_ready_i=0 -> ready_for_next_instrs_o goes low the cycle after count reaches 7. A subsequent 1-hit dispatch -> dropped, overflow_err_o=1, occupancy stays 7.
- Simultaneous push/pop at count 6: 2 hits plus a pop -> count 7; ready low. A later pop to count 6 -> ready high next cycle.
- Wrap-around: push/pop 20 entries (0..19) at a steady rate -> issued sequence 0..19 exact, pointers wrap twice, occupancy never exceeds 8.
- Flush and reset: flush_i at count 5 with a concurrent 2-hit push -> count 0, issue_valid_o 0, ready 0 for one cycle then 1, no overflow. reset_n low mid-stream -> all outputs at reset values the next cycle.
